// File: rtl/audio_session_ctrl.sv
// Session controller for the WM8731 record/playback path: slot bookkeeping,
// codec/recorder/DSP control sequencing and SRAM address/write-enable muxing.
module audio_session_ctrl #(
    parameter int ADDR_W    = 20,
    parameter int SLOT_BITS = 2,
    parameter int SPEED_W   = 3,
    localparam int OFF_W    = ADDR_W - SLOT_BITS,
    localparam int NSLOT    = 1 << SLOT_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_key_start,
    input  logic                 i_key_mode,
    input  logic                 i_key_stop,
    input  logic                 i_key_slot,
    input  logic                 i_loop,
    input  logic [SPEED_W-1:0]   i_speed,
    input  logic                 i_fast,
    input  logic                 i_slow_0,
    input  logic                 i_slow_1,
    input  logic                 i_i2c_finished,
    input  logic [OFF_W-1:0]     i_rec_addr,
    input  logic                 i_rec_overflow,
    input  logic [OFF_W-1:0]     i_play_addr,
    output logic                 o_i2c_start,
    output logic                 o_rec_start,
    output logic                 o_rec_pause,
    output logic                 o_rec_stop,
    output logic                 o_dsp_start,
    output logic                 o_dsp_pause,
    output logic                 o_dsp_stop,
    output logic [SPEED_W-1:0]   o_dsp_speed,
    output logic                 o_dsp_fast,
    output logic                 o_dsp_slow_0,
    output logic                 o_dsp_slow_1,
    output logic [ADDR_W-1:0]    o_sram_addr,
    output logic                 o_sram_we_n,
    output logic [SLOT_BITS-1:0] o_slot,
    output logic [6:0]           o_state,
    output logic [NSLOT-1:0]     o_slot_valid
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_I2C        = 3'd1,
        S_RECD       = 3'd2,
        S_RECD_PAUSE = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5,
        S_DONE       = 3'd6
    } state_e;

    state_e                    state_q, state_d;
    logic [SLOT_BITS-1:0]      slot_q, slot_d;
    logic                      init_q, init_d;
    logic [NSLOT-1:0][OFF_W-1:0] len_q;
    logic [NSLOT-1:0]          valid_q;

    logic                      i2c_start_q, rec_start_q, rec_pause_q, rec_stop_q;
    logic                      dsp_start_q, dsp_pause_q, dsp_stop_q, dsp_stop_d;
    logic                      we_n_q;
    logic [6:0]                state_oh_q;
    logic [SPEED_W-1:0]        speed_q;
    logic                      fast_q, slow0_q, slow1_q;

    logic k_stop, k_start, k_mode, k_slot;
    logic save, save_full, rec_nz, play_end, enter_play;

    // One key per cycle: stop > start > mode > slot.
    assign k_stop  = i_key_stop;
    assign k_start = i_key_start & ~k_stop;
    assign k_mode  = i_key_mode & ~k_stop & ~k_start;
    assign k_slot  = i_key_slot & ~k_stop & ~k_start & ~k_mode;

    assign rec_nz   = |i_rec_addr;
    // Suppressed during a stop pulse so a looping DSP gets one cycle to rewind.
    assign play_end = ~dsp_stop_q && (i_play_addr >= len_q[slot_q]);

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        init_d     = init_q;
        save       = 1'b0;
        save_full  = 1'b0;
        dsp_stop_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (k_start)                          state_d = init_q ? S_RECD : S_I2C;
                else if (k_mode && valid_q[slot_q])   state_d = S_PLAY;
                else if (k_slot)                      slot_d  = slot_q + SLOT_BITS'(1);
            end
            S_I2C: begin
                if (k_stop) state_d = S_IDLE;
                else if (i_i2c_finished) begin
                    init_d  = 1'b1;
                    state_d = S_RECD;
                end
            end
            S_RECD: begin
                if (i_rec_overflow) begin
                    save      = 1'b1;
                    save_full = 1'b1;
                    state_d   = S_IDLE;
                end else if (k_stop) begin
                    save    = 1'b1;
                    state_d = S_IDLE;
                end else if (k_start) state_d = S_RECD_PAUSE;
                else if (k_mode) begin
                    save    = 1'b1;
                    state_d = rec_nz ? S_PLAY : S_IDLE;
                end
            end
            S_RECD_PAUSE: begin
                if (k_stop) begin
                    save    = 1'b1;
                    state_d = S_IDLE;
                end else if (k_start) state_d = S_RECD;
                else if (k_mode) begin
                    save    = 1'b1;
                    state_d = rec_nz ? S_PLAY : S_IDLE;
                end else if (k_slot) begin
                    save    = 1'b1;
                    slot_d  = slot_q + SLOT_BITS'(1);
                    state_d = S_RECD;
                end
            end
            S_PLAY, S_PLAY_PAUSE: begin
                if (k_stop) begin
                    dsp_stop_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (k_start) state_d = (state_q == S_PLAY) ? S_PLAY_PAUSE : S_PLAY;
                else if (k_mode) begin
                    dsp_stop_d = 1'b1;
                    state_d    = S_RECD;
                end else if (state_q == S_PLAY && play_end) begin
                    dsp_stop_d = 1'b1;
                    if (!i_loop) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (k_stop)       state_d = S_IDLE;
                else if (k_start) state_d = S_PLAY;
                else if (k_mode)  state_d = S_RECD;
                else if (k_slot) begin
                    slot_d  = slot_q + SLOT_BITS'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_play = (state_d == S_PLAY) && (state_q != S_PLAY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            init_q      <= 1'b0;
            len_q       <= '0;
            valid_q     <= '0;
            i2c_start_q <= 1'b0;
            rec_start_q <= 1'b0;
            rec_pause_q <= 1'b0;
            rec_stop_q  <= 1'b0;
            dsp_start_q <= 1'b0;
            dsp_pause_q <= 1'b0;
            dsp_stop_q  <= 1'b0;
            we_n_q      <= 1'b1;
            state_oh_q  <= 7'd1;
            speed_q     <= '0;
            fast_q      <= 1'b0;
            slow0_q     <= 1'b0;
            slow1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            init_q      <= init_d;
            // Length is stored against the slot being left, before any slot change.
            if (save) begin
                len_q[slot_q]   <= save_full ? '1 : i_rec_addr;
                valid_q[slot_q] <= save_full | rec_nz;
            end
            i2c_start_q <= (state_d == S_I2C);
            rec_start_q <= (state_d == S_RECD);
            rec_pause_q <= (state_d == S_RECD_PAUSE);
            rec_stop_q  <= save;
            dsp_start_q <= (state_d == S_PLAY) && !dsp_stop_d;
            dsp_pause_q <= (state_d == S_PLAY_PAUSE);
            dsp_stop_q  <= dsp_stop_d;
            we_n_q      <= (state_d != S_RECD);
            state_oh_q  <= 7'd1 << state_d;
            if (enter_play) begin
                speed_q <= i_speed;
                fast_q  <= i_fast;
                slow0_q <= i_slow_0;
                slow1_q <= i_slow_1;
            end
        end
    end

    assign o_sram_addr = (state_q == S_RECD || state_q == S_RECD_PAUSE) ?
                         {slot_q, i_rec_addr} : {slot_q, i_play_addr};

    assign o_i2c_start  = i2c_start_q;
    assign o_rec_start  = rec_start_q;
    assign o_rec_pause  = rec_pause_q;
    assign o_rec_stop   = rec_stop_q;
    assign o_dsp_start  = dsp_start_q;
    assign o_dsp_pause  = dsp_pause_q;
    assign o_dsp_stop   = dsp_stop_q;
    assign o_dsp_speed  = speed_q;
    assign o_dsp_fast   = fast_q;
    assign o_dsp_slow_0 = slow0_q;
    assign o_dsp_slow_1 = slow1_q;
    assign o_sram_we_n  = we_n_q;
    assign o_slot       = slot_q;
    assign o_state      = state_oh_q;
    assign o_slot_valid = valid_q;

endmodule

// File: tb/tb_audio_session_ctrl.sv
// Directed bench for audio_session_ctrl: record, play, loop, slots, overflow, reset.
module tb_audio_session_ctrl;

    localparam int ADDR_W = 20;
    localparam int SLOT_BITS = 2;
    localparam int SPEED_W = 3;
    localparam int OFF_W = ADDR_W - SLOT_BITS;

    localparam logic [6:0] ST_IDLE = 7'd1,  ST_I2C = 7'd2,   ST_RECD = 7'd4, ST_RPAUSE = 7'd8,
                           ST_PLAY = 7'd16, ST_PPAUSE = 7'd32, ST_DONE = 7'd64;

    logic i_clk, i_rst_n;
    logic i_key_start, i_key_mode, i_key_stop, i_key_slot, i_loop;
    logic [SPEED_W-1:0] i_speed;
    logic i_fast, i_slow_0, i_slow_1, i_i2c_finished, i_rec_overflow;
    logic [OFF_W-1:0] i_rec_addr, i_play_addr;
    logic o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop;
    logic o_dsp_start, o_dsp_pause, o_dsp_stop;
    logic [SPEED_W-1:0] o_dsp_speed;
    logic o_dsp_fast, o_dsp_slow_0, o_dsp_slow_1;
    logic [ADDR_W-1:0] o_sram_addr;
    logic o_sram_we_n;
    logic [SLOT_BITS-1:0] o_slot;
    logic [6:0] o_state;
    logic [3:0] o_slot_valid;

    int n_chk = 0;
    int n_fail = 0;

    audio_session_ctrl #(.ADDR_W(ADDR_W), .SLOT_BITS(SLOT_BITS), .SPEED_W(SPEED_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_key_start(i_key_start), .i_key_mode(i_key_mode), .i_key_stop(i_key_stop),
        .i_key_slot(i_key_slot), .i_loop(i_loop), .i_speed(i_speed),
        .i_fast(i_fast), .i_slow_0(i_slow_0), .i_slow_1(i_slow_1),
        .i_i2c_finished(i_i2c_finished), .i_rec_addr(i_rec_addr),
        .i_rec_overflow(i_rec_overflow), .i_play_addr(i_play_addr),
        .o_i2c_start(o_i2c_start), .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause),
        .o_rec_stop(o_rec_stop), .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause),
        .o_dsp_stop(o_dsp_stop), .o_dsp_speed(o_dsp_speed), .o_dsp_fast(o_dsp_fast),
        .o_dsp_slow_0(o_dsp_slow_0), .o_dsp_slow_1(o_dsp_slow_1),
        .o_sram_addr(o_sram_addr), .o_sram_we_n(o_sram_we_n), .o_slot(o_slot),
        .o_state(o_state), .o_slot_valid(o_slot_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // 0=start 1=mode 2=stop 3=slot
    task automatic key(input int which);
        case (which)
            0: i_key_start = 1'b1;
            1: i_key_mode  = 1'b1;
            2: i_key_stop  = 1'b1;
            default: i_key_slot = 1'b1;
        endcase
        tick();
        i_key_start = 1'b0; i_key_mode = 1'b0; i_key_stop = 1'b0; i_key_slot = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_key_start = 0; i_key_mode = 0; i_key_stop = 0; i_key_slot = 0; i_loop = 0;
        i_speed = '0; i_fast = 0; i_slow_0 = 0; i_slow_1 = 0;
        i_i2c_finished = 0; i_rec_overflow = 0; i_rec_addr = '0; i_play_addr = '0;
        tick(); tick();
        chk("rst_state", 32'(o_state), 32'(ST_IDLE));
        chk("rst_we_n", 32'(o_sram_we_n), 32'd1);
        chk("rst_ctrl", 32'({o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop,
                             o_dsp_start, o_dsp_pause, o_dsp_stop}), 32'd0);
        chk("rst_valid", 32'(o_slot_valid), 32'd0);
        chk("rst_speed", 32'(o_dsp_speed), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // First start goes through codec init.
        key(0);
        chk("i2c_state", 32'(o_state), 32'(ST_I2C));
        chk("i2c_start", 32'(o_i2c_start), 32'd1);
        repeat (50) tick();
        chk("i2c_hold", 32'(o_state), 32'(ST_I2C));
        i_i2c_finished = 1'b1;
        tick();
        i_i2c_finished = 1'b0;
        chk("recd_state", 32'(o_state), 32'(ST_RECD));
        chk("recd_start", 32'(o_rec_start), 32'd1);
        chk("recd_we_n", 32'(o_sram_we_n), 32'd0);
        chk("i2c_drop", 32'(o_i2c_start), 32'd0);
        i_rec_addr = 18'h00005;
        #1 chk("recd_addr", 32'(o_sram_addr), 32'h00005);

        // Record to 0x100, switch to play with speed fields latched.
        i_rec_addr = 18'h00100; i_speed = 3'd5; i_fast = 1'b1;
        key(1);
        chk("play_state", 32'(o_state), 32'(ST_PLAY));
        chk("play_recstop", 32'(o_rec_stop), 32'd1);
        chk("play_valid", 32'(o_slot_valid), 32'b0001);
        chk("play_dstart", 32'(o_dsp_start), 32'd1);
        chk("play_speed", 32'(o_dsp_speed), 32'd5);
        chk("play_fast", 32'(o_dsp_fast), 32'd1);
        i_play_addr = 18'h00020; i_speed = 3'd2; i_fast = 1'b0;
        #1 chk("play_addr", 32'(o_sram_addr), 32'h00020);
        tick();
        chk("recstop_1cyc", 32'(o_rec_stop), 32'd0);
        chk("play_we_n", 32'(o_sram_we_n), 32'd1);
        chk("speed_held", 32'(o_dsp_speed), 32'd5);

        // Loop at end of recording.
        i_loop = 1'b1; i_play_addr = 18'h00100;
        tick();
        i_play_addr = 18'h0;
        chk("loop_stop", 32'({o_dsp_stop, o_dsp_start}), 32'b10);
        chk("loop_state", 32'(o_state), 32'(ST_PLAY));
        tick();
        chk("loop_resume", 32'({o_dsp_stop, o_dsp_start}), 32'b01);

        // No loop: end of recording goes to DONE.
        i_loop = 1'b0; i_play_addr = 18'h00100;
        tick();
        i_play_addr = 18'h0;
        chk("end_stop", 32'(o_dsp_stop), 32'd1);
        chk("end_state", 32'(o_state), 32'(ST_DONE));
        tick();
        chk("done_quiet", 32'({o_dsp_stop, o_dsp_start}), 32'b00);
        key(0);
        chk("done_replay", 32'(o_state), 32'(ST_PLAY));
        key(2);
        chk("stop_idle", 32'(o_state), 32'(ST_IDLE));
        chk("stop_dstop", 32'(o_dsp_stop), 32'd1);

        // Slot wrap and second recording without codec init.
        key(3); key(3); key(3);
        chk("slot3", 32'(o_slot), 32'd3);
        key(3);
        chk("slot_wrap", 32'(o_slot), 32'd0);
        key(3);
        i_rec_addr = 18'h00003;
        key(0);
        chk("rec2_state", 32'(o_state), 32'(ST_RECD));
        chk("rec2_noi2c", 32'(o_i2c_start), 32'd0);
        chk("rec2_addr", 32'(o_sram_addr), 32'h40003);
        i_key_stop = 1'b1;
        key(0);
        chk("stopstart", 32'(o_state), 32'(ST_IDLE));
        chk("stopstart_rs", 32'(o_rec_stop), 32'd1);
        chk("valid01", 32'(o_slot_valid), 32'b0011);
        key(3);
        key(1);
        chk("mode_invalid", 32'(o_state), 32'(ST_IDLE));

        // Overflow in slot 2 stores a full-length recording.
        i_rec_addr = 18'h00007;
        key(0);
        i_rec_overflow = 1'b1;
        tick();
        i_rec_overflow = 1'b0;
        chk("ovf_state", 32'(o_state), 32'(ST_IDLE));
        chk("ovf_rs", 32'(o_rec_stop), 32'd1);
        chk("ovf_valid", 32'(o_slot_valid), 32'b0111);
        i_play_addr = 18'h3FFFE;
        key(1);
        tick();
        chk("ovf_len_lo", 32'({o_state, o_dsp_stop}), 32'({ST_PLAY, 1'b0}));
        i_play_addr = 18'h3FFFF;
        tick();
        i_play_addr = 18'h0;
        chk("ovf_len_end", 32'({o_state, o_dsp_stop}), 32'({ST_DONE, 1'b1}));

        // Pause + slot change saves slot 3, zero-length mode clears slot 0.
        key(3);
        chk("done_slot", 32'({o_state, o_slot}), 32'({ST_IDLE, 2'd3}));
        i_rec_addr = 18'h00009;
        key(0);
        key(0);
        chk("rpause", 32'({o_state, o_rec_pause, o_sram_we_n}), 32'({ST_RPAUSE, 2'b11}));
        key(3);
        chk("pause_slot", 32'({o_state, o_slot, o_rec_stop}), 32'({ST_RECD, 2'd0, 1'b1}));
        chk("valid_all", 32'(o_slot_valid), 32'b1111);
        i_rec_addr = 18'h0;
        key(1);
        chk("zero_len", 32'({o_state, o_rec_stop}), 32'({ST_IDLE, 1'b1}));
        chk("zero_valid", 32'(o_slot_valid), 32'b1110);

        // Pause/resume re-latches speed, then reset mid-play.
        i_rec_addr = 18'h00010; i_speed = 3'd1;
        key(0);
        key(1);
        chk("play3_speed", 32'({o_state, o_dsp_speed}), 32'({ST_PLAY, 3'd1}));
        key(0);
        chk("ppause", 32'({o_state, o_dsp_pause, o_dsp_start}), 32'({ST_PPAUSE, 2'b10}));
        i_speed = 3'd6;
        key(0);
        chk("relatch", 32'({o_state, o_dsp_speed}), 32'({ST_PLAY, 3'd6}));
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(o_state), 32'(ST_IDLE));
        chk("arst_out", 32'({o_dsp_start, o_dsp_pause, o_dsp_stop, o_dsp_speed, o_slot}), 32'd0);
        chk("arst_valid", 32'(o_slot_valid), 32'd0);
        chk("arst_we_n", 32'(o_sram_we_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_session_ctrl.md
Name: audio_session_ctrl

Overview:
- Parametrised top-level session controller for the WM8731 record/playback path.
- Divides SRAM into 2^SLOT_BITS equal slots and remembers the recorded length of each slot.
- Drives codec init, recorder and DSP control; multiplexes the SRAM address and write enable.
- Adds behaviour the single-buffer controller lacks: stop at end of recording, optional loop playback, overflow handling, a one-time codec init, and speed settings latched glitch-free.

Parameters:
ADDR_W, 20, SRAM word-address width
SLOT_BITS, 2, log2 of the slot count; OFF_W = ADDR_W - SLOT_BITS (18 by default)
SPEED_W, 3, width of the DSP speed field

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_key_start  in  1  debounced 1-cycle pulse: start/pause toggle
i_key_mode  in  1  pulse: record <-> play switch
i_key_stop  in  1  pulse: stop to idle
i_key_slot  in  1  pulse: select next slot
i_loop  in  1  level: loop playback
i_speed  in  SPEED_W  speed request
i_fast, i_slow_0, i_slow_1  in  1 each  DSP mode requests
i_i2c_finished  in  1  codec init done (level)
i_rec_addr  in  OFF_W  recorder write offset
i_rec_overflow  in  1  recorder hit the end of its range
i_play_addr  in  OFF_W  DSP read offset
o_i2c_start  out  1  request codec init
o_rec_start, o_rec_pause, o_rec_stop  out  1 each  recorder controls
o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  DSP controls
o_dsp_speed  out  SPEED_W  latched speed
o_dsp_fast, o_dsp_slow_0, o_dsp_slow_1  out  1 each  latched modes
o_sram_addr  out  ADDR_W  {slot, offset}
o_sram_we_n  out  1  SRAM write enable, active low
o_slot  out  SLOT_BITS  current slot
o_state  out  7  one-hot state indicator
o_slot_valid  out  2^SLOT_BITS  slot holds a recording

Behaviour:
- States: IDLE, I2C, RECD, RECD_PAUSE, PLAY, PLAY_PAUSE, DONE. o_state bit n = state n, in that order.
- Reset:
  - state=IDLE, slot=0, all lengths=0, o_slot_valid=0, init_done=0.
  - All control outputs 0; o_sram_we_n=1.
  - o_dsp_speed=0; fast/slow outputs 0.
- Registering and latency:
  - All outputs except o_sram_addr are registered; each is a function of state_r plus 1-cycle pulse flags.
  - A key pulse at edge N changes state at edge N+1; outputs change in the same cycle.
- Key priority per cycle: stop > start > mode > slot. Lower-priority simultaneous keys are dropped.
- IDLE:
  - start → I2C if init_done=0, else RECD.
  - mode → PLAY if slot valid, else ignored.
  - slot → slot+1 modulo 2^SLOT_BITS.
- I2C: o_i2c_start=1 held until i_i2c_finished; then init_done=1 → RECD. Stop → IDLE, init_done stays 0.
- RECD:
  - o_rec_start=1, o_sram_we_n=0, o_sram_addr={slot, i_rec_addr}.
  - start → RECD_PAUSE.
  - stop → IDLE. mode → PLAY.
- RECD_PAUSE:
  - o_rec_pause=1, o_sram_we_n=1, address still from the recorder.
  - start → RECD. stop → IDLE. mode → PLAY.
  - slot → change slot, then RECD.
- Leaving RECD or RECD_PAUSE to IDLE, PLAY or another slot:
  - o_rec_stop pulses for 1 cycle.
  - len[slot] <= i_rec_addr, sampled on the exit edge; valid[slot] <= (i_rec_addr != 0).
  - A zero-length recording clears valid.
  - mode to an invalid slot goes to IDLE instead of PLAY.
- Overflow: i_rec_overflow while in RECD → len = all ones, valid=1, rec_stop pulse, then IDLE.
- PLAY:
  - o_dsp_start=1; o_sram_addr={slot, i_play_addr}; o_sram_we_n=1.
  - Speed/fast/slow fields latch from the inputs on each PLAY-entry edge and are held constant inside PLAY.
  - start → PLAY_PAUSE. stop → IDLE with a dsp_stop pulse. mode → RECD with a dsp_stop pulse.
  - End of recording, when i_play_addr >= len[slot]:
    - i_loop=1: 1-cycle o_dsp_stop with o_dsp_start=0, stay in PLAY, then o_dsp_start resumes.
    - i_loop=0: dsp_stop pulse, then DONE.
- PLAY_PAUSE: o_dsp_pause=1; start → PLAY (fields re-latched); stop and mode as in PLAY.
- DONE:
  - o_dsp_stop=0 and all controls 0.
  - start → PLAY, from offset 0 after the DSP stop.
  - stop → IDLE. mode → RECD. slot → slot+1, then IDLE.
- o_sram_addr is combinational from the current state and slot; in IDLE, I2C and DONE it is {slot, i_play_addr}.
- An asynchronous reset in any state returns to reset values immediately; lengths are lost.
- Invalid state encoding → IDLE on the next edge.

Test Plan:
- Reset, start pulse, i_i2c_finished after 50 cycles → o_state I2C (bit1) → RECD (bit2); o_rec_start=1; o_sram_we_n=0.
- Record to i_rec_addr=0x00100, then mode pulse → o_rec_stop high exactly 1 cycle; o_slot_valid[0]=1; PLAY; o_sram_addr=0x00000+play offset.
- PLAY with i_loop=0, i_play_addr reaches 0x00100 → single dsp_stop pulse, state DONE. With i_loop=1 → dsp_stop pulse, stays PLAY, dsp_start back after 1 cycle.
- Slot pulse in IDLE from slot 3 → slot 0. Record in slot 1 at offset 0x3 → o_sram_addr=0x40003. Mode pulse while slot 2 is invalid → stays IDLE.
- Simultaneous stop+start in RECD → IDLE, rec_stop pulse. Second start from IDLE → RECD directly; o_i2c_start never reasserts.
- i_rec_overflow in RECD → len[slot]=0x3FFFF, valid=1, IDLE. Asynchronous reset mid-PLAY → all outputs 0, o_slot_valid=0 at once.
